// File: rtl/cmpl_div_iter.sv
// Iterative 18-bit signed complex divider q = a / b, scaled by 2^FRAC_BITS, one operation in flight.
// Optional macro CMPL_DIV_ROUND_EN: one extra quotient bit for round-half-away-from-zero.
module cmpl_div_iter #(
  parameter int OUT_W     = 18,
  parameter int FRAC_BITS = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [17:0]      dataa_real,
  input  logic signed [17:0]      dataa_imag,
  input  logic signed [17:0]      datab_real,
  input  logic signed [17:0]      datab_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] result_real,
  output logic signed [OUT_W-1:0] result_imag,
  output logic                    ovf,
  output logic                    div0,
  output logic [1:0]              state_dbg
);

`ifdef CMPL_DIV_ROUND_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int ITER   = OUT_W - 1 + EXTRA;
  localparam int MAX_SH = (FRAC_BITS + EXTRA > OUT_W - 1) ? FRAC_BITS + EXTRA : OUT_W - 1;
  localparam int NW     = 37 + MAX_SH;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [ITER:0]    MAG_LIM = (ITER+1)'(1) << (OUT_W - 1);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid and data stay stable until then, and neither valid nor ready depends combinationally on the other.
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_t;
  state_t state;

  logic signed [17:0] a_re, a_im, b_re, b_im;
  logic [NW-1:0]      rem_re, rem_im, dsh;
  logic [ITER-1:0]    q_re, q_im;
  logic               neg_re, neg_im, sat_re, sat_im, dz;
  logic [4:0]         cnt;

  logic signed [35:0] p_rr, p_ii, p_ir, p_ri, bb_r, bb_i;
  logic signed [36:0] num_re, num_im;
  logic [36:0]        abs_re, abs_im;
  logic [35:0]        den;
  logic               den_zero, sat_re_c, sat_im_c, neg_re_c, neg_im_c;
  logic [NW-1:0]      lim;

  assign p_rr   = a_re * b_re;
  assign p_ii   = a_im * b_im;
  assign p_ir   = a_im * b_re;
  assign p_ri   = a_re * b_im;
  assign bb_r   = b_re * b_re;
  assign bb_i   = b_im * b_im;
  assign num_re = {p_rr[35], p_rr} + {p_ii[35], p_ii};
  assign num_im = {p_ir[35], p_ir} - {p_ri[35], p_ri};
  assign den    = $unsigned(bb_r) + $unsigned(bb_i);
  assign abs_re = num_re[36] ? -num_re : num_re;
  assign abs_im = num_im[36] ? -num_im : num_im;
  assign lim    = NW'(den) << (OUT_W - 1);

  // A zero denominator makes the cross products vanish too, so saturation follows the signs of a.
  assign den_zero = (den == '0);
  assign sat_re_c = den_zero ? (a_re != '0) : ((NW'(abs_re) << FRAC_BITS) >= lim);
  assign sat_im_c = den_zero ? (a_im != '0) : ((NW'(abs_im) << FRAC_BITS) >= lim);
  assign neg_re_c = den_zero ? a_re[17] : num_re[36];
  assign neg_im_c = den_zero ? a_im[17] : num_im[36];

  logic ge_re, ge_im;
  assign ge_re = (rem_re >= dsh);
  assign ge_im = (rem_im >= dsh);

  logic [ITER:0]           rnd_re, rnd_im;
  logic                    fsat_re, fsat_im;
  logic [OUT_W-1:0]        mag_re, mag_im;
  logic signed [OUT_W-1:0] fin_re, fin_im;

  always_comb begin
`ifdef CMPL_DIV_ROUND_EN
    rnd_re = ({1'b0, q_re} + (ITER+1)'(1)) >> 1;
    rnd_im = ({1'b0, q_im} + (ITER+1)'(1)) >> 1;
`else
    rnd_re = {1'b0, q_re};
    rnd_im = {1'b0, q_im};
`endif
    fsat_re = sat_re | (rnd_re >= MAG_LIM);
    fsat_im = sat_im | (rnd_im >= MAG_LIM);
    mag_re  = fsat_re ? MAX_POS : (dz ? '0 : rnd_re[OUT_W-1:0]);
    mag_im  = fsat_im ? MAX_POS : (dz ? '0 : rnd_im[OUT_W-1:0]);
    fin_re  = neg_re ? -$signed(mag_re) : $signed(mag_re);
    fin_im  = neg_im ? -$signed(mag_im) : $signed(mag_im);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result_real <= '0;
      result_imag <= '0;
      ovf         <= 1'b0;
      div0        <= 1'b0;
      cnt         <= '0;
      a_re        <= '0;
      a_im        <= '0;
      b_re        <= '0;
      b_im        <= '0;
      rem_re      <= '0;
      rem_im      <= '0;
      dsh         <= '0;
      q_re        <= '0;
      q_im        <= '0;
      neg_re      <= 1'b0;
      neg_im      <= 1'b0;
      sat_re      <= 1'b0;
      sat_im      <= 1'b0;
      dz          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_re     <= dataa_real;
            a_im     <= dataa_imag;
            b_re     <= datab_real;
            b_im     <= datab_imag;
            in_ready <= 1'b0;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          rem_re <= NW'(abs_re) << (FRAC_BITS + EXTRA);
          rem_im <= NW'(abs_im) << (FRAC_BITS + EXTRA);
          dsh    <= NW'(den) << (ITER - 1);
          q_re   <= '0;
          q_im   <= '0;
          neg_re <= neg_re_c;
          neg_im <= neg_im_c;
          sat_re <= sat_re_c;
          sat_im <= sat_im_c;
          dz     <= den_zero;
          cnt    <= 5'(ITER);
          state  <= S_DIV;
        end
        S_DIV: begin
          if (cnt != 5'd0) begin
            if (ge_re) rem_re <= rem_re - dsh;
            if (ge_im) rem_im <= rem_im - dsh;
            q_re <= {q_re[ITER-2:0], ge_re};
            q_im <= {q_im[ITER-2:0], ge_im};
            dsh  <= dsh >> 1;
            cnt  <= cnt - 5'd1;
          end else begin
            result_real <= fin_re;
            result_imag <= fin_im;
            ovf         <= fsat_re | fsat_im;
            div0        <= dz;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cmpl_div_iter.sv
// Self-checking bench for cmpl_div_iter: directed cases, backpressure, mid-op reset, random back-to-back ops.
// Define CMPL_DIV_ROUND_EN for both bench and design to check the rounding build.
module tb_cmpl_div_iter;
`ifdef CMPL_DIV_ROUND_EN
  localparam int LAT    = 20;
  localparam int RND_23 = 43691;
`else
  localparam int LAT    = 19;
  localparam int RND_23 = 43690;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, ovf, div0;
  logic signed [17:0] dataa_real = '0, dataa_imag = '0, datab_real = '0, datab_imag = '0;
  logic signed [17:0] result_real, result_imag;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];

  always #5 clock = ~clock;

  cmpl_div_iter dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dataa_real(dataa_real), .dataa_imag(dataa_imag),
    .datab_real(datab_real), .datab_imag(datab_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_real(result_real), .result_imag(result_imag),
    .ovf(ovf), .div0(div0), .state_dbg(state_dbg)
  );

  // Reference: exact integer quotient of num*2^16/den, saturated symmetrically.
  function automatic void comp(input longint num, input longint den, input int a_x,
                               output logic signed [17:0] r, output logic sat);
    longint m, q;
    if (den == 0) begin
      sat = (a_x != 0);
      q = sat ? 131071 : 0;
      r = (a_x < 0) ? 18'(-q) : 18'(q);
    end else begin
      m = (num < 0) ? -num : num;
      q = (m * 65536) / den;
`ifdef CMPL_DIV_ROUND_EN
      if (2 * ((m * 65536) % den) >= den) q = q + 1;
`endif
      sat = (q > 131071);
      if (sat) q = 131071;
      r = (num < 0) ? 18'(-q) : 18'(q);
    end
  endfunction

  function automatic logic [37:0] model(input logic signed [17:0] ar, ai, br, bi);
    longint nr, ni, den;
    logic signed [17:0] rr, ri;
    logic sr, si;
    nr  = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
    ni  = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
    den = longint'(br) * longint'(br) + longint'(bi) * longint'(bi);
    comp(nr, den, int'(ar), rr, sr);
    comp(ni, den, int'(ai), ri, si);
    return {rr, ri, sr | si, den == 0};
  endfunction

  function automatic logic signed [17:0] rnd(input int k);
    int v;
    v = int'($urandom_range(0, 2 * k)) - k;
    return 18'(v);
  endfunction

  task automatic issue_op(input logic signed [17:0] ar, ai, br, bi);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_wait in_ready=%b required 1", in_ready);
    end
    dataa_real = ar; dataa_imag = ai; datab_real = br; datab_imag = bi;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [37:0] obs);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    obs = {result_real, result_imag, ovf, div0};
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({in_ready, out_valid, ovf, div0} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags got %b want 1000", {in_ready, out_valid, ovf, div0});
    end
    checks++;
    if ({result_real, result_imag} !== 36'd0) begin
      errors++; $display("FAIL reset_results got %0d,%0d want 0,0", result_real, result_imag);
    end
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release in_ready,out_valid got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_directed();
    int t_ar[7] = '{100, -100, 0, 2, 300, 5, 0};
    int t_ai[7] = '{0, 0, 100, 0, -300, -5, 0};
    int t_br[7] = '{100, 0, 100, 3, 100, 0, 0};
    int t_bi[7] = '{0, 100, 0, 0, 0, 0, 0};
    int t_rr[7] = '{65536, 0, 0, RND_23, 131071, 131071, 0};
    int t_ri[7] = '{0, 65536, 65536, 0, -131071, -131071, 0};
    int t_ov[7] = '{0, 0, 0, 0, 1, 1, 0};
    int t_d0[7] = '{0, 0, 0, 0, 0, 1, 1};
    int lat;
    logic [37:0] obs, exp_v;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({18'(t_rr[i]), 18'(t_ri[i]), 1'(t_ov[i]), 1'(t_d0[i])});
      issue_op(18'(t_ar[i]), 18'(t_ai[i]), 18'(t_br[i]), 18'(t_bi[i]));
      wait_result(lat, obs);
      exp_v = exp_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL directed%0d_result got %0d,%0d ovf=%b div0=%b want %0d,%0d ovf=%b div0=%b", i,
                 $signed(obs[37:20]), $signed(obs[19:2]), obs[1], obs[0],
                 $signed(exp_v[37:20]), $signed(exp_v[19:2]), exp_v[1], exp_v[0]);
      end
      accept();
      checks++;
      if ({in_ready, out_valid, ovf, div0} !== 4'b1000) begin
        errors++; $display("FAIL directed%0d_release got %b want 1000", i, {in_ready, out_valid, ovf, div0});
      end
    end
  endtask

  task automatic test_early_ready();
    int lat;
    logic [37:0] obs, exp_v;
    out_ready = 1'b1;
    exp_q.push_back(model(18'sd1, 18'sd0, 18'sd4, 18'sd0));
    issue_op(18'sd1, 18'sd0, 18'sd4, 18'sd0);
    wait_result(lat, obs);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || lat !== LAT) begin
      errors++; $display("FAIL early_ready_result got %h lat %0d want %h lat %0d", obs, lat, exp_v, LAT);
    end
    @(negedge clock);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL early_ready_accept got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [37:0] obs, exp_v;
    logic signed [17:0] ar, ai, br, bi;
    ar = rnd(20000); ai = rnd(20000); br = rnd(30000); bi = rnd(30000);
    exp_q.push_back(model(ar, ai, br, bi));
    issue_op(ar, ai, br, bi);
    wait_result(lat, obs);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL backpressure_result got %h want %h", obs, exp_v);
    end
    dataa_real = 18'sd7; dataa_imag = 18'sd9; datab_real = 18'sd1; datab_imag = 18'sd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || {result_real, result_imag, ovf, div0} !== obs) begin
        errors++;
        $display("FAIL backpressure_hold%0d got v=%b r=%b %h want v=1 r=0 %h", i, out_valid, in_ready,
                 {result_real, result_imag, ovf, div0}, obs);
      end
    end
    in_valid = 1'b0;
    accept();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL backpressure_release got %b want 10", {in_ready, out_valid});
    end
    repeat (25) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_ignored_input out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    logic [37:0] obs, exp_v;
    issue_op(18'sd1234, -18'sd999, 18'sd77, 18'sd55);
    repeat (8) @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    checks++;
    if ({in_ready, out_valid, ovf, div0} !== 4'b1000 || {result_real, result_imag} !== 36'd0) begin
      errors++;
      $display("FAIL midop_reset got flags %b res %0d,%0d want 1000 res 0,0",
               {in_ready, out_valid, ovf, div0}, result_real, result_imag);
    end
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_release in_ready=%b want 1", in_ready);
    end
    repeat (25) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midop_no_partial out_valid=%b want 0", out_valid);
    end
    exp_q.push_back(model(-18'sd4321, 18'sd2500, 18'sd300, -18'sd150));
    issue_op(-18'sd4321, 18'sd2500, 18'sd300, -18'sd150);
    wait_result(lat, obs);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v || lat !== LAT) begin
      errors++; $display("FAIL midop_next_op got %h lat %0d want %h lat %0d", obs, lat, exp_v, LAT);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [37:0] obs, exp_v;
    logic signed [17:0] ar, ai, br, bi;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin ar = 18'($urandom); ai = 18'($urandom); br = 18'($urandom); bi = 18'($urandom); end
        1: begin ar = rnd(1000); ai = rnd(1000); br = 18'($urandom); bi = 18'($urandom); end
        2: begin ar = rnd(5000); ai = rnd(5000); br = rnd(5000); bi = rnd(5000); end
        default: begin ar = rnd(50); ai = rnd(50); br = rnd(3); bi = rnd(3); end
      endcase
      exp_q.push_back(model(ar, ai, br, bi));
      issue_op(ar, ai, br, bi);
      wait_result(lat, obs);
      exp_v = exp_q.pop_front();
      checks++;
      if (lat !== LAT) begin
        errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, LAT);
      end
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b%0d_result a=(%0d,%0d) b=(%0d,%0d) got %0d,%0d ovf=%b div0=%b want %0d,%0d ovf=%b div0=%b",
                 i, ar, ai, br, bi, $signed(obs[37:20]), $signed(obs[19:2]), obs[1], obs[0],
                 $signed(exp_v[37:20]), $signed(exp_v[19:2]), exp_v[1], exp_v[0]);
      end
      accept();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_early_ready();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
